// File: rtl/muldiv_sequencer.sv
// Iterative multiply/divide sequencer for the execute stage.
// MUL uses a shift-add loop, UDIV/SDIV use a restoring divider. Both run
// for exactly WIDTH iterations. Divide-by-zero and the reserved op finish
// immediately with a zero result. The pipeline is stalled while an op is
// being accepted or is in flight.
//
// state | meaning
// IDLE  | waiting for start; operands are latched on acceptance
// CALC  | one datapath iteration per cycle, WIDTH cycles in total
// DONE  | result presented with result_valid for one cycle
module muldiv_sequencer #(
  parameter int WIDTH = 64,
  parameter int CNT_W = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             flush,
  output logic             stall,
  output logic [WIDTH-1:0] result,
  output logic             result_valid
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  localparam logic [1:0] OP_MUL  = 2'b00;
  localparam logic [1:0] OP_UDIV = 2'b01;
  localparam logic [1:0] OP_SDIV = 2'b10;
  localparam logic [1:0] OP_RSVD = 2'b11;

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       op_r;
  // a_r: multiplicand for MUL; dividend shifting out / quotient shifting in for divides
  logic [WIDTH-1:0] a_r;
  // b_r: multiplier for MUL; divisor magnitude for divides
  logic [WIDTH-1:0] b_r;
  // acc: product for MUL; partial remainder (WIDTH+1 bits) for divides
  logic [WIDTH:0]   acc;
  logic             neg_r;
  logic             dz_r;
  logic [WIDTH-1:0] result_q;

  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic             early_done;
  logic [WIDTH:0]   trial;
  logic             take;
  logic [WIDTH-1:0] res_calc;

  // Operand magnitudes, early-exit decode and the restoring-divide trial step
  always_comb begin
    abs_a = operand_a[WIDTH-1] ? (~operand_a + WIDTH'(1)) : operand_a;
    abs_b = operand_b[WIDTH-1] ? (~operand_b + WIDTH'(1)) : operand_b;
    early_done = (op == OP_RSVD) ||
                 ((op != OP_MUL) && (operand_b == '0));
    trial = {acc[WIDTH-1:0], a_r[WIDTH-1]};
    take  = (trial >= {1'b0, b_r});
  end

  // Final value: zero for the early-exit cases, product low half, or signed-corrected quotient
  always_comb begin
    res_calc = '0;
    if (!dz_r) begin
      if (op_r == OP_MUL)
        res_calc = acc[WIDTH-1:0];
      else if (neg_r)
        res_calc = ~a_r + WIDTH'(1);
      else
        res_calc = a_r;
    end
  end

  // result_valid and stall must react to flush and reset within the same cycle,
  // so they are decoded from the registered state rather than registered themselves.
  // Outside DONE the result register keeps the last delivered value.
  always_comb begin
    result_valid = !reset && !flush && (state == DONE);
    stall        = !reset && !flush &&
                   ((state == CALC) || ((state == IDLE) && start));
    result       = (state == DONE) ? res_calc : result_q;
  end

  // Sequencer FSM and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      op_r     <= '0;
      a_r      <= '0;
      b_r      <= '0;
      acc      <= '0;
      neg_r    <= 1'b0;
      dz_r     <= 1'b0;
      result_q <= '0;
    end else if (flush) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op_r  <= op;
            cnt   <= '0;
            acc   <= '0;
            neg_r <= 1'b0;
            dz_r  <= early_done;
            if (op == OP_SDIV) begin
              a_r   <= abs_a;
              b_r   <= abs_b;
              neg_r <= operand_a[WIDTH-1] ^ operand_b[WIDTH-1];
            end else begin
              a_r <= operand_a;
              b_r <= operand_b;
            end
            state <= early_done ? DONE : CALC;
          end
        end
        CALC: begin
          cnt <= cnt + CNT_W'(1);
          if (op_r == OP_MUL) begin
            if (b_r[0])
              acc <= {1'b0, acc[WIDTH-1:0] + a_r};
            a_r <= a_r << 1;
            b_r <= b_r >> 1;
          end else begin
            acc <= take ? (trial - {1'b0, b_r}) : trial;
            a_r <= {a_r[WIDTH-2:0], take};
          end
          if (cnt == LAST_ITER)
            state <= DONE;
        end
        DONE: begin
          result_q <= res_calc;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: latency, results, stall, flush and reset behaviour.
module tb_muldiv_sequencer;

  localparam int W = 64;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] operand_a;
  logic [W-1:0] operand_b;
  logic         flush;
  logic         stall;
  logic [W-1:0] result;
  logic         result_valid;

  int checks = 0;
  int errors = 0;

  muldiv_sequencer #(.WIDTH(W), .CNT_W(7)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .op(op),
    .operand_a(operand_a),
    .operand_b(operand_b),
    .flush(flush),
    .stall(stall),
    .result(result),
    .result_valid(result_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Drive start for one cycle, then count cycles until result_valid.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] exp, input int lat);
    int  cyc;
    logic stall_ok;
    op = o; operand_a = a; operand_b = b; start = 1'b1;
    #1;
    chk({tag, "_stall_accept"}, W'(stall), W'(1));
    tick();
    start = 1'b0;
    #1;
    cyc = 1;
    stall_ok = 1'b1;
    while (result_valid !== 1'b1 && cyc < 200) begin
      if (stall !== 1'b1) stall_ok = 1'b0;
      tick();
      #1;
      cyc++;
    end
    chk({tag, "_latency"}, W'(cyc), W'(lat));
    chk({tag, "_result"}, result, exp);
    chk({tag, "_stall_busy"}, W'(stall_ok), W'(1));
    chk({tag, "_stall_done"}, W'(stall), W'(0));
    tick();
    #1;
    chk({tag, "_pulse_end"}, W'(result_valid), W'(0));
    chk({tag, "_result_hold"}, result, exp);
  endtask

  initial begin
    reset = 1'b1; start = 1'b1; op = 2'b00; flush = 1'b0;
    operand_a = 64'd5; operand_b = 64'd3;
    #12;
    chk("reset_stall", W'(stall), W'(0));
    chk("reset_valid", W'(result_valid), W'(0));
    chk("reset_result", result, 64'd0);
    start = 1'b0;
    tick();
    reset = 1'b0;
    tick();

    run_op("mul_shift", 2'b00, 64'h0000_0000_0001_0000, 64'h0000_0000_0003_0000,
           64'h0000_0003_0000_0000, 65);
    run_op("mul_dec", 2'b00, 64'd123456789, 64'd1000, 64'd123456789000, 65);
    run_op("mul_allones", 2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 65);
    run_op("udiv_100_7", 2'b01, 64'd100, 64'd7, 64'd14, 65);
    run_op("udiv_max_1", 2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 65);
    run_op("udiv_small", 2'b01, 64'd7, 64'd100, 64'd0, 65);
    run_op("udiv_big", 2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 65);
    run_op("sdiv_n100_7", 2'b10, -64'sd100, 64'd7, 64'hFFFF_FFFF_FFFF_FFF2, 65);
    run_op("sdiv_100_n7", 2'b10, 64'd100, -64'sd7, 64'hFFFF_FFFF_FFFF_FFF2, 65);
    run_op("sdiv_n100_n7", 2'b10, -64'sd100, -64'sd7, 64'd14, 65);
    run_op("sdiv_min_n1", 2'b10, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
           64'h8000_0000_0000_0000, 65);
    run_op("udiv_by0", 2'b01, 64'd55, 64'd0, 64'd0, 1);
    run_op("sdiv_by0", 2'b10, 64'd55, 64'd0, 64'd0, 1);
    run_op("op_rsvd", 2'b11, 64'd55, 64'd9, 64'd0, 1);

    // Reset at T+10 of a UDIV
    op = 2'b01; operand_a = 64'd100; operand_b = 64'd7; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    chk("pre_reset_stall", W'(stall), W'(1));
    reset = 1'b1;
    #1;
    chk("reset_mid_stall", W'(stall), W'(0));
    chk("reset_mid_valid", W'(result_valid), W'(0));
    tick();
    reset = 1'b0;
    repeat (70) begin
      tick();
      chk("reset_mid_no_pulse", W'(result_valid), W'(0));
    end
    run_op("after_reset", 2'b01, 64'd1000, 64'd10, 64'd100, 65);

    // Flush at T+30 of a MUL, then back-to-back start at T+31
    op = 2'b00; operand_a = 64'd3; operand_b = 64'd4; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (29) tick();
    flush = 1'b1;
    #1;
    chk("flush_calc_stall", W'(stall), W'(0));
    chk("flush_calc_valid", W'(result_valid), W'(0));
    tick();
    flush = 1'b0;
    run_op("after_flush", 2'b00, 64'd6, 64'd7, 64'd42, 65);

    // Flush in the DONE cycle of a MUL
    op = 2'b00; operand_a = 64'd11; operand_b = 64'd13; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (64) tick();
    flush = 1'b1;
    #1;
    chk("flush_done_valid", W'(result_valid), W'(0));
    chk("flush_done_stall", W'(stall), W'(0));
    tick();
    flush = 1'b0;
    #1;
    chk("flush_done_after", W'(result_valid), W'(0));
    chk("flush_done_idle", W'(stall), W'(0));

    // Flush in the DONE cycle of a divide-by-zero, and flush beating start
    op = 2'b01; operand_a = 64'd9; operand_b = 64'd0; start = 1'b1;
    tick();
    start = 1'b0;
    flush = 1'b1;
    #1;
    chk("flush_dz_valid", W'(result_valid), W'(0));
    start = 1'b1;
    #1;
    chk("flush_over_start_stall", W'(stall), W'(0));
    tick();
    start = 1'b0;
    flush = 1'b0;
    repeat (3) begin
      tick();
      chk("flush_over_start_idle", W'(stall), W'(0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
Iterative multi-cycle multiply/divide controller in the execute stage. It accepts MUL, UDIV and SDIV requests, sequences a shift-add or restoring-divide datapath over WIDTH cycles, and stalls the pipeline until the result is ready. The main single-cycle ALU continues to handle ADD/SUB/AND/ORR/CBZ. This block owns only the long-latency ops.

Parameters:
WIDTH, 64, operand/result width in bits (power of 2, >=8)
CNT_W, 7, iteration counter width; must satisfy 2^CNT_W > WIDTH

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high; clears all state
start  input  1  request valid from the execute stage
op  input  2  00=MUL, 01=UDIV, 10=SDIV, 11=reserved
operand_a  input  WIDTH  multiplicand / dividend (Rn)
operand_b  input  WIDTH  multiplier / divisor (Rm)
flush  input  1  pipeline flush; aborts any op in flight
stall  output  1  hold IF/ID/EX pipeline registers
result  output  WIDTH  product low WIDTH bits or quotient
result_valid  output  1  one-cycle pulse; result valid this cycle

Behaviour:
- Reset values: state=IDLE, counter=0, all internal registers 0; result=0, result_valid=0.
- stall during reset: 0 regardless of start.
- Asynchronous reset mid-operation: abandons the op immediately and produces no result_valid.
- States: IDLE, CALC, DONE.
- IDLE:
  - start=1 and flush=0: latch operands and op, set counter=0.
  - MUL or U/SDIV with operand_b!=0: go to CALC.
  - UDIV/SDIV with operand_b==0, or op=11: go to DONE with result=0 (ARMv8 divide-by-zero result is 0).
- CALC: one iteration per cycle. Counter increments each cycle. Leave for DONE after the cycle with counter==WIDTH-1, so exactly WIDTH CALC cycles.
- MUL: shift-add. Low WIDTH bits only; signedness is irrelevant for the low half.
- UDIV: restoring division. Partial remainder is WIDTH+1 bits. The quotient bit is set when (rem<<1 | next dividend bit) >= divisor.
- SDIV:
  - Divide the magnitudes |a|/|b| unsigned.
  - Negate the quotient if sign(a) XOR sign(b).
  - Truncate toward zero.
  - MIN / -1 returns MIN (modular wrap, no trap).
- DONE: drive result, result_valid=1 for exactly one cycle, then go to IDLE. result holds its value until the next DONE.
- stall is combinational:
  - 1 in IDLE when start=1 and flush=0.
  - 1 throughout CALC.
  - 0 in DONE and in idle-without-start.
- Pipeline contract: execute holds start/op/operands stable while stall=1. The pipeline advances in the DONE cycle and must not re-assert start for the same instruction.
- start is ignored outside IDLE. A new start may be accepted in the cycle after DONE, which is zero bubble cycles beyond the normal advance.
- Latency (start accepted at cycle T):
  - MUL/normal divide: result_valid at T+WIDTH+1.
  - Divide-by-zero or reserved op: result_valid at T+1.
- flush=1:
  - In any state, next state is IDLE.
  - No result_valid is produced; a pending DONE is suppressed if flush=1 in that cycle.
  - stall=0 in that cycle.
  - flush takes priority over start.

Test Plan:
- Reset mid-CALC: assert reset at cycle T+10 of a UDIV -> stall=0 and result_valid=0 immediately. An idle start then works normally.
- MUL a=0x0000_0000_0001_0000, b=0x0000_0000_0003_0000 -> result=0x0000_0003_0000_0000 with result_valid at T+65. stall=1 for cycles T..T+64.
- UDIV a=100, b=7 -> result=14 at T+65. UDIV a=0xFFFF_FFFF_FFFF_FFFF, b=1 -> result=0xFFFF_FFFF_FFFF_FFFF.
- SDIV cases:
  - a=-100, b=7 -> result=-14 (0xFFFF_FFFF_FFFF_FFF2).
  - a=0x8000_0000_0000_0000, b=-1 -> result=0x8000_0000_0000_0000.
- Divide-by-zero: UDIV/SDIV a=55, b=0 -> result=0 with result_valid at T+1; op=11 -> result=0 at T+1.
- Flush at T+30 of a MUL -> next state IDLE, no result_valid pulse. A back-to-back start at T+31 completes normally at T+96. Flush asserted in the DONE cycle -> no pulse.
